// File: rtl/cam_roi_feature_extractor.sv
// OV7670 RGB565 front-end: oversampled byte capture, ROI colour/luma/green
// statistics and one feature record per frame on a valid/ready handshake.
module cam_roi_feature_extractor #(
    parameter logic [7:0] ROW_START = 8'd208,
    parameter logic [9:0] COL_START = 10'd288,
    parameter int         ROI_LOG2  = 6,
    parameter logic [7:0] GREEN_THR = 8'd96
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [7:0]          cam_d,
    input  logic                cam_pclk,
    input  logic                cam_href,
    input  logic                cam_vsync,
    output logic                feat_valid,
    input  logic                feat_ready,
    output logic [7:0]          avg_red,
    output logic [7:0]          avg_green,
    output logic [7:0]          avg_blue,
    output logic [7:0]          avg_luma,
    output logic [2*ROI_LOG2:0] green_count,
    output logic [7:0]          green_height,
    output logic                frame_err,
    output logic [7:0]          overrun_cnt
);

    localparam int AW = 2*ROI_LOG2+8;
    localparam int CW = 2*ROI_LOG2+1;
    localparam int PW = CW+1;
    localparam logic [9:0]    SIDE10 = 10'(1 << ROI_LOG2);
    localparam logic [PW-1:0] NPIX   = {2'b01, {(2*ROI_LOG2){1'b0}}};

    typedef enum logic [1:0] {S_SYNC, S_ACTIVE, S_FINAL} state_t;

    logic pclk_s1_q, pclk_s2_q, pclk_s3_q;
    logic href_s1_q, href_s2_q, href_s3_q;
    logic vs_s1_q, vs_s2_q, vs_s3_q;
    logic [7:0] d_s1_q, d_s2_q;

    logic [10:0] byte_cnt_q;
    logic [9:0]  line_cnt_q;
    logic [7:0]  hi_q;

    state_t state_q, state_d;
    logic   clr_acc, load_out;

    logic [AW-1:0] r_acc_q, g_acc_q, b_acc_q, y_acc_q;
    logic [PW-1:0] pix_cnt_q;
    logic [CW-1:0] grn_cnt_q;
    logic          grn_any_q, line_odd_q;
    logic [7:0]    grn_top_q, grn_bot_q;

    logic byte_evt, vsync_rise, href_rise, href_fall, pix_evt;
    logic [10:0] byte_idx;
    logic [9:0]  col, rel_col, rel_row;
    logic [4:0]  r5, b5;
    logic [5:0]  g6;
    logic [7:0]  r8, g8, b8, y8;
    logic [9:0]  luma10;
    logic        green, in_roi, acc_pix;

    assign byte_evt   = pclk_s2_q & ~pclk_s3_q & href_s2_q;
    assign vsync_rise = vs_s2_q & ~vs_s3_q;
    assign href_rise  = href_s2_q & ~href_s3_q;
    assign href_fall  = ~href_s2_q & href_s3_q;
    assign byte_idx   = href_rise ? 11'd0 : byte_cnt_q;
    assign pix_evt    = byte_evt & byte_idx[0];

    assign r5 = hi_q[7:3];
    assign g6 = {hi_q[2:0], d_s2_q[7:5]};
    assign b5 = d_s2_q[4:0];
    assign r8 = {r5, r5[4:2]};
    assign g8 = {g6, g6[5:4]};
    assign b8 = {b5, b5[4:2]};
    assign luma10 = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
    assign y8 = 8'(luma10 >> 2);
    assign green = (g8 > r8) && (g8 > b8) && (g8 >= GREEN_THR);

    // Below-start coordinates wrap to large values, so one compare bounds both sides.
    assign col     = byte_idx[10:1];
    assign rel_col = col - COL_START;
    assign rel_row = line_cnt_q - {2'b00, ROW_START};
    assign in_roi  = (rel_row < SIDE10) && (rel_col < SIDE10);
    assign acc_pix = pix_evt & in_roi & (state_q == S_ACTIVE);

    // Two-flop synchronisers plus edge-detect stages for the camera inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s1_q <= 1'b0; pclk_s2_q <= 1'b0; pclk_s3_q <= 1'b0;
            href_s1_q <= 1'b0; href_s2_q <= 1'b0; href_s3_q <= 1'b0;
            vs_s1_q   <= 1'b0; vs_s2_q   <= 1'b0; vs_s3_q   <= 1'b0;
            d_s1_q    <= 8'd0; d_s2_q    <= 8'd0;
        end else if (ena) begin
            pclk_s1_q <= cam_pclk;  pclk_s2_q <= pclk_s1_q;
            pclk_s3_q <= pclk_s2_q;
            href_s1_q <= cam_href;  href_s2_q <= href_s1_q;
            href_s3_q <= href_s2_q;
            vs_s1_q   <= cam_vsync; vs_s2_q   <= vs_s1_q;
            vs_s3_q   <= vs_s2_q;
            d_s1_q    <= cam_d;     d_s2_q    <= d_s1_q;
        end
    end

    // Byte/line position tracking and the high byte of the current pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= 11'd0;
            line_cnt_q <= 10'd0;
            hi_q       <= 8'd0;
        end else if (ena) begin
            if (byte_evt) byte_cnt_q <= byte_idx + 11'd1;
            else if (href_rise) byte_cnt_q <= 11'd0;
            if (vsync_rise) line_cnt_q <= 10'd0;
            else if (href_fall) line_cnt_q <= line_cnt_q + 10'd1;
            if (byte_evt && !byte_idx[0]) hi_q <= d_s2_q;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_SYNC;
        else if (ena) state_q <= state_d;
    end

    // Frame sequencing: first vsync arms capture, later ones finalise.
    always_comb begin
        state_d  = state_q;
        clr_acc  = 1'b0;
        load_out = 1'b0;
        unique case (state_q)
            S_SYNC: if (vsync_rise) begin
                state_d = S_ACTIVE;
                clr_acc = 1'b1;
            end
            S_ACTIVE: if (vsync_rise) state_d = S_FINAL;
            S_FINAL: begin
                load_out = 1'b1;
                clr_acc  = 1'b1;
                state_d  = S_ACTIVE;
            end
            default: state_d = S_SYNC;
        endcase
    end

    // ROI statistics accumulation and geometry error tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_q <= '0; g_acc_q <= '0; b_acc_q <= '0; y_acc_q <= '0;
            pix_cnt_q <= '0; grn_cnt_q <= '0; grn_any_q <= 1'b0;
            grn_top_q <= 8'd0; grn_bot_q <= 8'd0; line_odd_q <= 1'b0;
        end else if (ena) begin
            if (clr_acc) begin
                r_acc_q <= '0; g_acc_q <= '0; b_acc_q <= '0; y_acc_q <= '0;
                pix_cnt_q <= '0; grn_cnt_q <= '0; grn_any_q <= 1'b0;
                grn_top_q <= 8'd0; grn_bot_q <= 8'd0; line_odd_q <= 1'b0;
            end else begin
                if (href_fall && byte_cnt_q[0]) line_odd_q <= 1'b1;
                if (acc_pix) begin
                    r_acc_q <= r_acc_q + AW'(r8);
                    g_acc_q <= g_acc_q + AW'(g8);
                    b_acc_q <= b_acc_q + AW'(b8);
                    y_acc_q <= y_acc_q + AW'(y8);
                    if (pix_cnt_q != '1) pix_cnt_q <= pix_cnt_q + PW'(1);
                    if (green) begin
                        grn_cnt_q <= grn_cnt_q + CW'(1);
                        grn_bot_q <= rel_row[7:0];
                        if (!grn_any_q) grn_top_q <= rel_row[7:0];
                        grn_any_q <= 1'b1;
                    end
                end
            end
        end
    end

    // Output record and handshake; a new record overwrites an unaccepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_valid <= 1'b0; avg_red <= 8'd0; avg_green <= 8'd0;
            avg_blue <= 8'd0; avg_luma <= 8'd0; green_count <= '0;
            green_height <= 8'd0; frame_err <= 1'b0; overrun_cnt <= 8'd0;
        end else if (ena) begin
            if (load_out) begin
                feat_valid   <= 1'b1;
                avg_red      <= r_acc_q[AW-1:2*ROI_LOG2];
                avg_green    <= g_acc_q[AW-1:2*ROI_LOG2];
                avg_blue     <= b_acc_q[AW-1:2*ROI_LOG2];
                avg_luma     <= y_acc_q[AW-1:2*ROI_LOG2];
                green_count  <= grn_cnt_q;
                green_height <= grn_any_q ? grn_bot_q - grn_top_q + 8'd1 : 8'd0;
                frame_err    <= (pix_cnt_q != NPIX) | line_odd_q;
                if (feat_valid && !feat_ready && overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end else if (feat_valid && feat_ready) begin
                feat_valid <= 1'b0;
            end
        end
    end

endmodule
